led_blink_scheduler: RTL and testbench



---
 rtl/led_blink_scheduler.sv | 117 +++++++++++
 tb/tb_led_blink_scheduler.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/led_blink_scheduler.sv
// Round-robin LED blink-code scheduler: grants one of four requesters, plays its
// pulse code on a shared LED using a tick prescaler, then pulses ack.
`timescale 1ns / 1ps
module led_blink_scheduler #(
  parameter int unsigned CLK_DIV   = 1250,
  parameter int unsigned ON_TICKS  = 4,
  parameter int unsigned OFF_TICKS = 4,
  parameter int unsigned GAP_TICKS = 20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [3:0]  req,
  input  logic [11:0] code,
  output logic [3:0]  ack,
  output logic        busy,
  output logic [1:0]  grant_id,
  output logic        led_drive
);

  typedef enum logic [2:0] {StIdle, StOn, StOff, StGap, StAck} state_e;

  state_e      state;
  logic [15:0] prescaler;
  logic [7:0]  tick_cnt;
  logic [3:0]  pulse_cnt;
  logic [1:0]  last_grant;

  logic        tick;
  logic [7:0]  state_len;
  logic [1:0]  cand;
  logic [1:0]  next_id;
  logic [2:0]  next_field;
  logic [3:0]  next_pulses;

  assign tick = (prescaler == 16'(CLK_DIV - 1));

  always_comb begin
    state_len = 8'(GAP_TICKS);
    if (state == StOn) begin
      state_len = 8'(ON_TICKS);
    end else if (state == StOff) begin
      state_len = 8'(OFF_TICKS);
    end
  end

  // Walk offsets 4..1 so the nearest set bit after last_grant is written last.
  always_comb begin
    next_id = last_grant;
    cand    = '0;
    for (int i = 4; i >= 1; i--) begin
      cand = last_grant + i[1:0];
      if (req[cand]) next_id = cand;
    end
  end

  assign next_field  = code[3*next_id +: 3];
  assign next_pulses = (next_field == 3'd0) ? 4'd8 : {1'b0, next_field};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= StIdle;
      prescaler  <= '0;
      tick_cnt   <= '0;
      pulse_cnt  <= '0;
      grant_id   <= '0;
      last_grant <= 2'd3;
    end else begin
      unique case (state)
        StIdle: begin
          prescaler <= '0;
          tick_cnt  <= '0;
          if (enable && (|req)) begin
            state      <= StOn;
            grant_id   <= next_id;
            last_grant <= next_id;
            pulse_cnt  <= next_pulses;
          end
        end
        StOn, StOff, StGap: begin
          prescaler <= tick ? '0 : prescaler + 16'd1;
          if (tick) begin
            if (tick_cnt == state_len - 8'd1) begin
              tick_cnt <= '0;
              if (state == StOn) begin
                if (pulse_cnt == 4'd1) begin
                  state <= StGap;
                end else begin
                  pulse_cnt <= pulse_cnt - 4'd1;
                  state     <= StOff;
                end
              end else if (state == StOff) begin
                state <= StOn;
              end else begin
                state <= StAck;
              end
            end else begin
              tick_cnt <= tick_cnt + 8'd1;
            end
          end
        end
        StAck: begin
          prescaler <= '0;
          tick_cnt  <= '0;
          state     <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  // Outputs decode the state register directly; enable masks the LED at once.
  assign busy      = (state != StIdle);
  assign led_drive = (state == StOn) & enable;
  assign ack       = (state == StAck) ? (4'b0001 << grant_id) : 4'b0000;

endmodule

// File: tb/tb_led_blink_scheduler.sv
// Directed bench for led_blink_scheduler with a short tick (CLK_DIV=4).
`timescale 1ns / 1ps
module tb_led_blink_scheduler;

  localparam int DIV  = 4;
  localparam int ONT  = 2;
  localparam int OFFT = 2;
  localparam int GAPT = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b1;
  logic [3:0]  req = '0;
  logic [11:0] code = '0;
  logic [3:0]  ack;
  logic        busy;
  logic [1:0]  grant_id;
  logic        led_drive;

  int compared = 0;
  int mismatched = 0;

  led_blink_scheduler #(
    .CLK_DIV  (DIV),
    .ON_TICKS (ONT),
    .OFF_TICKS(OFFT),
    .GAP_TICKS(GAPT)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (enable),
    .req      (req),
    .code     (code),
    .ack      (ack),
    .busy     (busy),
    .grant_id (grant_id),
    .led_drive(led_drive)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_led"}, 32'(led_drive), 0);
    chk({tag, "_ack"}, 32'(ack), 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req     = '0;
    enable  = 1'b1;
    #1;
    check_idle_outputs("reset");
    chk("reset_grant_id", 32'(grant_id), 0);
    step();
    reset_n = 1'b1;
  endtask

  // Serve one code: expects grant to id, n pulses, vis_pulses of them visible.
  task automatic run_service(input int id, input int n, input int vis_pulses,
                             input int drop_en_at, input bit drop_req);
    bit   seen;
    bit   done;
    int   cyc;
    int   k;
    int   pulses;
    int   active;
    logic prev;
    logic exp_led;
    seen = 0;
    for (int w = 0; w < 40 && !seen; w++) begin
      step();
      if (busy) seen = 1;
    end
    chk("grant_seen", 32'(seen), 1);
    if (!seen) return;
    active = n * ONT * DIV + (n - 1) * OFFT * DIV;
    done = 0;
    cyc = 0;
    pulses = 0;
    prev = 1'b0;
    while (!done && cyc < 400) begin
      cyc++;
      if (cyc == drop_en_at) begin
        enable = 1'b0;
        #1;
      end
      k = cyc - 1;
      exp_led = enable && (k < active) && ((k % ((ONT + OFFT) * DIV)) < ONT * DIV);
      chk("busy_in_service", 32'(busy), 1);
      if (cyc == 1) chk("grant_id", 32'(grant_id), 32'(id));
      chk("led_pattern", 32'(led_drive), 32'(exp_led));
      if (led_drive && !prev) pulses++;
      prev = led_drive;
      if (ack != 4'b0000) done = 1;
      else step();
    end
    chk("ack_onehot", 32'(ack), 32'(1 << id));
    chk("service_len", 32'(cyc), 32'(active + GAPT * DIV + 1));
    chk("pulse_count", 32'(pulses), 32'(vis_pulses));
    if (drop_req) req[id] = 1'b0;
    step();
    chk("idle_after_ack_busy", 32'(busy), 0);
    chk("ack_cleared", 32'(ack), 0);
  endtask

  initial begin
    // Basic 3-pulse code on requester 0.
    do_reset();
    code = 12'o0003;
    req  = 4'b0001;
    run_service(0, 3, 3, 0, 1);

    // All four requesting with code 1: served 0,1,2,3.
    do_reset();
    code = 12'o1111;
    req  = 4'b1111;
    for (int i = 0; i < 4; i++) run_service(i, 1, 1, 0, 1);
    chk("rr_all_served", 32'(req), 0);

    // req[1] and req[2] held: grants alternate.
    do_reset();
    code = 12'o1111;
    req  = 4'b0110;
    run_service(1, 1, 1, 0, 0);
    run_service(2, 1, 1, 0, 0);
    run_service(1, 1, 1, 0, 0);
    run_service(2, 1, 1, 0, 0);

    // Code field 0 on requester 3 means 8 pulses.
    req  = 4'b1000;
    code = 12'o0111;
    run_service(3, 8, 8, 0, 1);

    // enable low in IDLE: no grant.
    enable = 1'b0;
    code   = 12'o0020;
    req    = 4'b0010;
    for (int i = 0; i < 20; i++) begin
      step();
      check_idle_outputs("disabled_idle");
    end
    // Enable, then drop it mid-ON: LED masked, timing and ack unchanged.
    enable = 1'b1;
    run_service(1, 2, 1, 3, 1);
    enable = 1'b1;

    // Reset during OFF of a 5-pulse code on requester 2.
    code = 12'o0501;
    req  = 4'b0100;
    step();
    chk("r5_busy", 32'(busy), 1);
    chk("r5_grant", 32'(grant_id), 2);
    repeat (10) step();
    chk("r5_in_off_led", 32'(led_drive), 0);
    chk("r5_in_off_busy", 32'(busy), 1);
    reset_n = 1'b0;
    #1;
    check_idle_outputs("midreset");
    chk("midreset_grant", 32'(grant_id), 0);
    step();
    check_idle_outputs("midreset_edge");
    reset_n = 1'b1;
    req = 4'b0101;
    run_service(0, 1, 1, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
